// File: rtl/sw_array_ctrl.sv
// rtl/sw_array_ctrl.sv - job sequencer and running max-score reduction for a linear SW systolic array
// Optional SW_CTRL_MAXPOS_EN adds max_row_o/max_col_o (position of the best score).
module sw_array_ctrl #(
  parameter int N_PE          = 16,
  parameter int BP_WIDTH      = 2,
  parameter int CALC_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [ADDRESS_WIDTH-1:0]   q_len_i,
  input  logic [ADDRESS_WIDTH-1:0]   t_len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [ADDRESS_WIDTH-1:0]   q_addr_o,
  input  logic [BP_WIDTH-1:0]        q_data_i,
  output logic [ADDRESS_WIDTH-1:0]   t_addr_o,
  input  logic [BP_WIDTH-1:0]        t_data_i,
  output logic                       arr_reset_n_o,
  output logic [BP_WIDTH-1:0]        s_o,
  output logic                       s_update_o,
  output logic [BP_WIDTH-1:0]        t_o,
  output logic                       valid_o,
  input  logic [N_PE*CALC_WIDTH-1:0] h_vec_i,
  output logic [CALC_WIDTH-1:0]      max_score_o
`ifdef SW_CTRL_MAXPOS_EN
  ,
  output logic [ADDRESS_WIDTH-1:0]   max_row_o,
  output logic [ADDRESS_WIDTH-1:0]   max_col_o
`endif
);

  localparam int CW = ADDRESS_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CLR, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                          state, state_d;
  logic [CW-1:0]                   cnt, cnt_d;
  logic [ADDRESS_WIDTH-1:0]        q_len_q, t_len_q;
  logic                            err_q;
  logic                            len_bad;
  logic signed [CALC_WIDTH-1:0]    max_q, best, h_i;
  logic                            in_window;
`ifdef SW_CTRL_MAXPOS_EN
  logic [ADDRESS_WIDTH-1:0]        row_q, col_q, best_row, best_col;
`endif

  assign len_bad     = (q_len_q == '0) || (t_len_q == '0) || (q_len_q > ADDRESS_WIDTH'(N_PE));
  assign err_o       = err_q;
  assign max_score_o = max_q;
`ifdef SW_CTRL_MAXPOS_EN
  assign max_row_o   = row_q;
  assign max_col_o   = col_q;
`endif

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    busy_o        = (state != S_IDLE);
    done_o        = 1'b0;
    arr_reset_n_o = 1'b0;
    q_addr_o      = '0;
    t_addr_o      = '0;
    s_o           = '0;
    s_update_o    = 1'b0;
    t_o           = '0;
    valid_o       = 1'b0;
    case (state)
      S_IDLE: if (start_i) state_d = S_CHECK;
      S_CHECK: begin
        cnt_d   = '0;
        state_d = len_bad ? S_DONE : S_CLR;
      end
      S_CLR: begin
        if (cnt == CW'(1)) begin
          q_addr_o = q_len_q - ADDRESS_WIDTH'(1);
          cnt_d    = '0;
          state_d  = S_LOAD;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_LOAD: begin
        arr_reset_n_o = 1'b1;
        s_update_o    = 1'b1;
        s_o           = q_data_i;
        // Query goes in highest index first so q[0] ends up sitting in PE0.
        if (cnt == {1'b0, q_len_q} - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_FEED;
        end else begin
          q_addr_o = q_len_q - ADDRESS_WIDTH'(2) - cnt[ADDRESS_WIDTH-1:0];
          cnt_d    = cnt + CW'(1);
        end
      end
      S_FEED: begin
        arr_reset_n_o = 1'b1;
        t_o           = t_data_i;
        valid_o       = (cnt == '0);
        t_addr_o      = cnt[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(1);
        cnt_d         = cnt + CW'(1);
        if (cnt == {1'b0, t_len_q} - CW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        arr_reset_n_o = 1'b1;
        cnt_d         = cnt + CW'(1);
        if (cnt == {1'b0, q_len_q} + {1'b0, t_len_q}) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cnt counts cycles since F0 during FEED/DRAIN; PE i carries column j = cnt-i-1.
  always_comb begin
    best      = max_q;
    h_i       = '0;
    in_window = 1'b0;
`ifdef SW_CTRL_MAXPOS_EN
    best_row  = row_q;
    best_col  = col_q;
`endif
    for (int i = 0; i < N_PE; i++) begin
      h_i       = $signed(h_vec_i[i*CALC_WIDTH +: CALC_WIDTH]);
      in_window = (state == S_FEED || state == S_DRAIN) &&
                  (CW'(i) < {1'b0, q_len_q}) && (cnt > CW'(i)) &&
                  (cnt <= CW'(i) + {1'b0, t_len_q});
      if (in_window && (h_i > best)) begin
        best     = h_i;
`ifdef SW_CTRL_MAXPOS_EN
        best_row = ADDRESS_WIDTH'(i);
        best_col = ADDRESS_WIDTH'(cnt - CW'(i) - CW'(1));
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      q_len_q <= '0;
      t_len_q <= '0;
      err_q   <= 1'b0;
      max_q   <= '0;
`ifdef SW_CTRL_MAXPOS_EN
      row_q   <= '0;
      col_q   <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == S_IDLE && start_i) begin
        q_len_q <= q_len_i;
        t_len_q <= t_len_i;
        err_q   <= 1'b0;
        max_q   <= '0;
`ifdef SW_CTRL_MAXPOS_EN
        row_q   <= '0;
        col_q   <= '0;
`endif
      end else begin
        if (state == S_CHECK && len_bad) err_q <= 1'b1;
        max_q <= best;
`ifdef SW_CTRL_MAXPOS_EN
        row_q <= best_row;
        col_q <= best_col;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// tb/tb_sw_array_ctrl.sv - scoreboard bench for sw_array_ctrl with memory and PE-output models
module tb_sw_array_ctrl;

  localparam int NPE  = 4;
  localparam int BPW  = 2;
  localparam int CW   = 16;
  localparam int AW   = 10;
  localparam int TMAX = 8;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic [AW-1:0]     q_len_i, t_len_i;
  logic              busy_o, done_o, err_o;
  logic [AW-1:0]     q_addr_o, t_addr_o;
  logic [BPW-1:0]    q_data_i, t_data_i;
  logic              arr_reset_n_o;
  logic [BPW-1:0]    s_o, t_o;
  logic              s_update_o, valid_o;
  logic [NPE*CW-1:0] h_vec_i;
  logic [CW-1:0]     max_score_o;
`ifdef SW_CTRL_MAXPOS_EN
  logic [AW-1:0]     max_row_o, max_col_o;
`endif

  always #5 clk = ~clk;

  sw_array_ctrl #(.N_PE(NPE), .BP_WIDTH(BPW), .CALC_WIDTH(CW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i), .q_len_i(q_len_i), .t_len_i(t_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .q_addr_o(q_addr_o), .q_data_i(q_data_i), .t_addr_o(t_addr_o), .t_data_i(t_data_i),
    .arr_reset_n_o(arr_reset_n_o), .s_o(s_o), .s_update_o(s_update_o), .t_o(t_o),
    .valid_o(valid_o), .h_vec_i(h_vec_i), .max_score_o(max_score_o)
`ifdef SW_CTRL_MAXPOS_EN
    , .max_row_o(max_row_o), .max_col_o(max_col_o)
`endif
  );

  typedef struct { int max; int row; int col; int err; } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, rel = -1, q_len_cur = 0, t_len_cur = 0;
  int   s_cnt = 0, v_cnt = 0, arr_cnt = 0, done_cnt = 0, done_cyc = 0;
  int   h_tab [NPE][TMAX];
  logic [1:0] q_mem [0:1023];
  logic [1:0] t_mem [0:1023];
  exp_t exp_q [$];
  int   exp_s [$];

  task automatic chk_eq(string tag, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Synchronous base memories: one-cycle read latency.
  always @(posedge clk) begin
    q_data_i <= q_mem[q_addr_o];
    t_data_i <= t_mem[t_addr_o];
  end

  // Monitor: sampled 1 ns after the edge; also plays the PE array by driving h_vec_i.
  initial begin
    exp_t e;
    logic [NPE*CW-1:0] hv;
    h_vec_i = {NPE{16'h7FFF}};
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset_i) begin
        rel = -1;
        h_vec_i = {NPE{16'h7FFF}};
        continue;
      end
      if (s_update_o) begin
        s_cnt++;
        if (exp_s.size() > 0) chk_eq("s_o", s_o, exp_s.pop_front());
        else chk_eq("s_update_extra", 1, 0);
      end
      if (valid_o) begin
        v_cnt++;
        rel = 0;
      end else if (rel >= 0) begin
        rel++;
      end
      if (arr_reset_n_o) arr_cnt++;
      if (rel >= 0 && rel < t_len_cur) chk_eq("t_o", t_o, t_mem[rel]);
      // Out-of-window slots carry a huge value the reduction must mask off.
      for (int i = 0; i < NPE; i++) begin
        if (rel >= 0 && i < q_len_cur && rel >= i + 1 && rel <= i + t_len_cur)
          hv[i*CW +: CW] = 16'(h_tab[i][rel-i-1]);
        else
          hv[i*CW +: CW] = 16'h7FFF;
      end
      h_vec_i = hv;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        rel = -1;
        if (exp_q.size() == 0) begin
          chk_eq("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("max_score", int'($signed(max_score_o)), e.max);
          chk_eq("err_at_done", err_o, e.err);
`ifdef SW_CTRL_MAXPOS_EN
          chk_eq("max_row", max_row_o, e.row);
          chk_eq("max_col", max_col_o, e.col);
`endif
        end
      end
    end
  end

  // Expected best: highest value; ties go to smallest cycle (i+j), then smallest i.
  function automatic exp_t find_best(int ql, int tl);
    exp_t r;
    r.max = 0; r.row = 0; r.col = 0; r.err = 0;
    for (int i = 0; i < ql; i++)
      for (int j = 0; j < tl; j++) begin
        int v;
        v = h_tab[i][j];
        if (v > r.max || (v == r.max && v > 0 &&
            (i + j < r.row + r.col || (i + j == r.row + r.col && i < r.row)))) begin
          r.max = v; r.row = i; r.col = j;
        end
      end
    return r;
  endfunction

  // Linear-gap local alignment, match +2 / mismatch -1 / gap -1.
  task automatic sw_fill(int ql, int tl);
    for (int i = 0; i < ql; i++)
      for (int j = 0; j < tl; j++) begin
        int d, u, l, m;
        d = ((i > 0 && j > 0) ? h_tab[i-1][j-1] : 0) + ((q_mem[i] == t_mem[j]) ? 2 : -1);
        u = (i > 0) ? h_tab[i-1][j] - 1 : 0;
        l = (j > 0) ? h_tab[i][j-1] - 1 : 0;
        m = 0;
        if (d > m) m = d;
        if (u > m) m = u;
        if (l > m) m = l;
        h_tab[i][j] = m;
      end
  endtask

  task automatic fill_h(int lo, int hi);
    for (int i = 0; i < NPE; i++)
      for (int j = 0; j < TMAX; j++) h_tab[i][j] = $urandom_range(hi - lo, 0) + lo;
  endtask

  task automatic rand_mem();
    for (int k = 0; k < 16; k++) begin
      q_mem[k] = 2'($urandom_range(3, 0));
      t_mem[k] = 2'($urandom_range(3, 0));
    end
  endtask

  task automatic launch(int ql, int tl, bit bad, output int sc);
    q_len_cur = ql;
    t_len_cur = tl;
    if (!bad) for (int k = 0; k < ql; k++) exp_s.push_back(q_mem[ql-1-k]);
    s_cnt = 0; v_cnt = 0; arr_cnt = 0;
    @(posedge clk); #2;
    sc = cyc;
    q_len_i = AW'(ql);
    t_len_i = AW'(tl);
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(int d0);
    int budget;
    budget = 0;
    while (done_cnt == d0 && budget < 300) begin
      @(posedge clk); #2;
      budget++;
    end
    if (done_cnt == d0) chk_eq("done_timeout", 0, 1);
  endtask

  task automatic run_job(int ql, int tl, bit bad);
    exp_t e;
    int d0, sc;
    if (bad) begin
      e.max = 0; e.row = 0; e.col = 0; e.err = 1;
    end else begin
      e = find_best(ql, tl);
    end
    exp_q.push_back(e);
    d0 = done_cnt;
    launch(ql, tl, bad, sc);
    wait_done(d0);
    if (bad) chk_eq("err_done_latency", done_cyc - sc, 2);
    repeat (3) begin @(posedge clk); #2; end
    chk_eq("done_pulses", done_cnt - d0, 1);
    chk_eq("busy_after", busy_o, 0);
    chk_eq("max_hold", int'($signed(max_score_o)), e.max);
    chk_eq("err_hold", err_o, e.err);
    chk_eq("valid_pulses", v_cnt, bad ? 0 : 1);
    chk_eq("s_update_cycles", s_cnt, bad ? 0 : ql);
    chk_eq("arr_released", (arr_cnt > 0) ? 1 : 0, bad ? 0 : 1);
    chk_eq("s_left", exp_s.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, d0, gap, budget;
    for (int k = 0; k < 1024; k++) begin q_mem[k] = 2'd0; t_mem[k] = 2'd0; end
    reset_i = 1'b1; start_i = 1'b0; q_len_i = '0; t_len_i = '0;
    repeat (2) @(posedge clk);
    #2;
    reset_i = 1'b0;
    @(posedge clk); #2;
    chk_eq("rst_busy", busy_o, 0);
    chk_eq("rst_done", done_o, 0);
    chk_eq("rst_err", err_o, 0);
    chk_eq("rst_arr_reset_n", arr_reset_n_o, 0);
    chk_eq("rst_s_update", s_update_o, 0);
    chk_eq("rst_valid", valid_o, 0);
    chk_eq("rst_max", max_score_o, 0);
    chk_eq("rst_q_addr", q_addr_o, 0);
    chk_eq("rst_t_addr", t_addr_o, 0);

    // ACGT vs ACGT: diagonal 2,4,6,8.
    for (int k = 0; k < 4; k++) begin q_mem[k] = 2'(k); t_mem[k] = 2'(k); end
    sw_fill(4, 4);
    chk_eq("model_acgt_peak", h_tab[3][3], 8);
    run_job(4, 4, 1'b0);

    // Bad lengths: too long, empty query, empty target.
    run_job(5, 4, 1'b1);
    chk_eq("err_still_held", err_o, 1);
    run_job(0, 3, 1'b1);
    run_job(2, 0, 1'b1);

    // Short query: PE2/PE3 carry 0x7FFF and must be masked.
    rand_mem();
    fill_h(1, 500);
    run_job(2, 3, 1'b0);

    // Equal peaks in different cycles: earlier (PE1,j0) wins over (PE0,j2).
    fill_h(1, 5);
    h_tab[1][0] = 10;
    h_tab[0][2] = 10;
    run_job(2, 3, 1'b0);

    // Equal peaks in the same cycle: lower PE index wins.
    fill_h(1, 5);
    h_tab[0][1] = 12;
    h_tab[1][0] = 12;
    run_job(2, 3, 1'b0);

    // All-negative scores: signed compare keeps the initial 0.
    fill_h(-300, -1);
    run_job(3, 2, 1'b0);

    // Longer random job at full query width.
    rand_mem();
    fill_h(0, 2000);
    run_job(4, 7, 1'b0);

    // Reset in FEED: abort, no done, then a clean rerun.
    for (int k = 0; k < 4; k++) begin q_mem[k] = 2'(k); t_mem[k] = 2'(k); end
    sw_fill(4, 4);
    d0 = done_cnt;
    launch(4, 4, 1'b0, sc);
    budget = 0;
    while (rel != 1 && budget < 100) begin @(posedge clk); #2; budget++; end
    chk_eq("reached_feed", rel, 1);
    #1 reset_i = 1'b1;
    #1;
    chk_eq("abort_busy", busy_o, 0);
    chk_eq("abort_arr_reset_n", arr_reset_n_o, 0);
    chk_eq("abort_valid", valid_o, 0);
    chk_eq("abort_max", max_score_o, 0);
    @(posedge clk); #2;
    reset_i = 1'b0;
    exp_s.delete();
    repeat (20) begin @(posedge clk); #2; end
    chk_eq("abort_no_done", done_cnt - d0, 0);
    chk_eq("abort_idle_busy", busy_o, 0);
    run_job(4, 4, 1'b0);

    // start_i held across a job: back-to-back jobs with one idle cycle between.
    fill_h(1, 50);
    exp_q.push_back(find_best(2, 2));
    exp_q.push_back(find_best(2, 2));
    for (int r = 0; r < 2; r++) for (int k = 0; k < 2; k++) exp_s.push_back(q_mem[1-k]);
    q_len_cur = 2; t_len_cur = 2; v_cnt = 0;
    d0 = done_cnt;
    @(posedge clk); #2;
    q_len_i = AW'(2); t_len_i = AW'(2); start_i = 1'b1;
    wait_done(d0);
    gap = 0; budget = 0;
    while (budget < 10) begin
      @(posedge clk); #2;
      budget++;
      if (!busy_o) gap++;
      else if (gap > 0) break;
    end
    start_i = 1'b0;
    chk_eq("idle_gap", gap, 1);
    wait_done(d0 + 1);
    repeat (3) begin @(posedge clk); #2; end
    chk_eq("held_jobs_done", done_cnt - d0, 2);
    chk_eq("held_valid_pulses", v_cnt, 2);
    chk_eq("held_busy_after", busy_o, 0);
    chk_eq("exp_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
- Sequencer for one linear systolic array of N_PE two-piece-affine PEs.
- Per job it:
  - fetches the query and target from synchronous base memories;
  - clears the array;
  - shift-loads the query;
  - streams the target with the one-shot valid;
  - reduces every active PE's H each cycle to the running best local score.
- Sits between the job host and the PE chain.

Parameters:
- N_PE, 16, PEs in array; maximum query length per job
- BP_WIDTH, 2, bits per base
- CALC_WIDTH, 16, signed score width
- ADDRESS_WIDTH, 10, base-memory address width and length-field width

Ports:
- clk  in  1  clock
- reset_i  in  1  asynchronous reset, active-high
- start_i  in  1  job request, sampled only in IDLE
- q_len_i  in  ADDRESS_WIDTH  query length, captured on accepted start
- t_len_i  in  ADDRESS_WIDTH  target length, captured on accepted start
- busy_o  out  1  high from accepted start through the DONE cycle
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  set with done_o on bad lengths; held until next accepted start
- q_addr_o  out  ADDRESS_WIDTH  query memory read address
- q_data_i  in  BP_WIDTH  query base, valid one cycle after q_addr_o
- t_addr_o  out  ADDRESS_WIDTH  target memory read address
- t_data_i  in  BP_WIDTH  target base, valid one cycle after t_addr_o
- arr_reset_n_o  out  1  active-low array reset
- s_o  out  BP_WIDTH  query base to PE0
- s_update_o  out  1  query load strobe to PE0
- t_o  out  BP_WIDTH  target base to PE0
- valid_o  out  1  first-column strobe to PE0
- h_vec_i  in  N_PE*CALC_WIDTH  H_out of every PE; PE i at bits [i*CALC_WIDTH +: CALC_WIDTH]
- max_score_o  out  CALC_WIDTH  best score of current/last job

Behaviour:
- Reset values:
  - state IDLE;
  - all outputs 0, except arr_reset_n_o=0 (array held in reset).
- Reset mid-job aborts immediately; no done_o is produced.
- Accepted start:
  - IDLE and start_i=1 latches both lengths;
  - clears max_score_o and err_o;
  - busy_o goes high the next cycle.
- Length check (in CHECK state):
  - q_len=0, t_len=0 or q_len>N_PE -> go to DONE with err_o=1;
  - array untouched; max_score_o stays 0.
- CLR (2 cycles):
  - arr_reset_n_o=0;
  - q_addr_o=q_len-1 issued in the 2nd cycle as the prefetch.
- LOAD (q_len cycles):
  - arr_reset_n_o=1;
  - s_update_o=1, s_o=q_data_i;
  - bases emitted in descending index q[q_len-1]..q[0];
  - q_addr_o decrements each cycle;
  - last LOAD cycle issues t_addr_o=0.
- FEED (t_len cycles):
  - s_update_o=0;
  - t_o=t_data_i in order t[0]..t[t_len-1];
  - valid_o=1 only in the first FEED cycle (F0);
  - t_addr_o increments each cycle.
- DRAIN:
  - t_o=0;
  - wait until cycle F0+q_len+t_len, then one more cycle for the reduction register;
  - then DONE.
- DONE (1 cycle): done_o=1, busy_o=1; then IDLE.
- Max reduction:
  - PE i holds H(i,j) in cycle F0+i+j+1;
  - PE i is active when i<q_len and 0 <= cycle-F0-i-1 < t_len;
  - each cycle, a combinational max over active PEs is compared to the running max (initial 0, signed);
  - the running max updates on strictly greater only, so the earliest cycle wins; within a cycle the lower PE index wins;
  - the result is registered, one cycle of latency;
  - max_score_o is stable after done_o.
- start_i while busy is ignored.
- Address counters never wrap within a legal job.

Optional Feature:
- SW_CTRL_MAXPOS_EN defined:
  - adds outputs max_row_o (ADDRESS_WIDTH, PE index) and max_col_o (ADDRESS_WIDTH, target index j);
  - both are updated together with max_score_o under the same tie rules;
  - reset and start clear them to 0.
- Undefined: these ports and their registers are absent.

Test Plan:
- N_PE=4, q="ACGT", t="ACGT", MATCH=2 -> s_o sequence T,G,C,A with s_update_o 4 cycles; valid_o one pulse; max_score_o=8; with SW_CTRL_MAXPOS_EN, row=3, col=3; done_o one pulse.
- q_len=5 with N_PE=4 -> done_o 2 cycles after start, err_o=1, arr_reset_n_o never released, s_update_o/valid_o never high.
- q_len=2, t_len=3, h_vec_i forces PE3 slice to 0x7FFF throughout -> max_score_o ignores PE3 (mask); equals max of PE0/PE1 stimulated values.
- Equal peak 10 injected at PE1 cycle F0+2 and PE0 cycle F0+3 -> max_score_o=10, max_row_o=1, max_col_o=0.
- reset_i pulsed during FEED -> all outputs to reset values next edge, busy_o=0, no done_o; new start runs a clean job.
- start_i held high across a whole job -> second job begins only after return to IDLE; busy_o low for exactly one cycle between jobs.
